cipher_round_ctrl: RTL and testbench
====================================

// Module: cipher_round_ctrl
// PURPOSE
//  Parametrised encrypt/decrypt sequencer for the toy block cipher; successor to the fixed decrypt-only top.
//  Loads the round key serially in KEY_CHUNK_W chunks, accepts start with a mode bit, steps round_no up (enc)
//  or down (dec), and iterates the state through an external combinational round datapath. It also drives
//  key_gen through key_out/round_no. It adds a real reset, a key-valid handshake and busy/done/err status.
// PARAMETERS
//  WORD_W      9    bits per state word (sbox width)
//  NUM_WORDS   4    words per state; STATE_W = WORD_W*NUM_WORDS (36)
//  KEY_CHUNK_W 16   key chunk width per transfer
//  KEY_W       144  full key width; must be a multiple of KEY_CHUNK_W (NCHUNK = KEY_W/KEY_CHUNK_W = 9)
//  NUM_ROUNDS  10   rounds per operation; 1..2^RND_W-1
//  RND_W       7    round_no width
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            async active-low reset
//  key_valid  in   1            key_chunk valid
//  key_chunk  in   KEY_CHUNK_W  key data, most-significant chunk first
//  key_ready  out  1            chunk accepted on a cycle with key_valid & key_ready
//  key_loaded out  1            full key present
//  key_out    out  KEY_W        assembled key, to key_gen
//  start      in   1            start request (single-cycle sample)
//  mode       in   1            0 = encrypt, 1 = decrypt; sampled with an accepted start
//  data_in    in   STATE_W      plaintext/ciphertext; sampled with an accepted start
//  busy       out  1            operation in progress
//  done       out  1            one-cycle pulse: data_out valid
//  err        out  1            one-cycle pulse: start rejected
//  data_out   out  STATE_W      result; holds until the next done
//  round_no   out  RND_W        current round index, to key_gen and the datapath
//  rd_mode    out  1            latched mode, to the datapath
//  rd_in      out  STATE_W      state register, to the datapath
//  rd_out     in   STATE_W      datapath result for (rd_in, round_no, rd_mode)
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE; key_out, key_loaded, chunk count, busy, done, err, data_out, round_no,
//   rd_mode and rd_in are all cleared to 0. The reset is honoured at any point, including mid-RUN (no done).
//  FSM states are IDLE and RUN; busy = (state==RUN).
//  Key load:
//   - key_ready = IDLE & ~start (combinational). Accepted chunk: key_out <= {key_out[KEY_W-KEY_CHUNK_W-1:0], key_chunk}.
//   - The first chunk of a load clears key_loaded. The chunk counter counts 0..NCHUNK-1.
//   - The NCHUNK-th accepted chunk sets key_loaded and wraps the counter to 0.
//   - Chunks arriving while busy or alongside start are not accepted (the source holds key_valid).
//  Start acceptance: in IDLE, start & key_loaded.
//   - On accept: rd_in <= data_in; rd_mode <= mode; round_no <= mode ? NUM_ROUNDS : 1; state <= RUN.
//   - err pulses (next cycle, one cycle) when start is high and any of these holds: RUN, ~key_loaded, or a
//     partial load is in progress. In that case nothing else changes.
//  RUN, each cycle: rd_in <= rd_out. The last round is round_no==NUM_ROUNDS (enc) or round_no==1 (dec).
//   - If not the last round: round_no is incremented (enc) or decremented (dec).
//   - If the last round: data_out <= rd_out; done <= 1; round_no <= 0; state <= IDLE.
//  Latency: start sampled at edge k. Rounds are applied at edges k+1..k+NUM_ROUNDS. done is high for the
//   single cycle after edge k+NUM_ROUNDS.
//  Back-to-back: a start in the done cycle is accepted (IDLE); throughput is one op per NUM_ROUNDS+1 cycles.
//  key_out is stable for the whole RUN, because key loading is blocked while busy.
//  round_no = 0 in IDLE. rd_out is ignored outside RUN.
// TESTING
//  1 Reset: assert rst_n=0 mid-sim -> all outputs 0, key_ready=1, key_loaded=0.
//  2 Key load: chunks 16'h0001..16'h0009 with gaps in key_valid -> key_out=144'h0001_0002_..._0009;
//    key_loaded rises after the 9th chunk only.
//  3 Rejects: start with key_loaded=0 -> err pulse, busy=0; start during RUN -> err pulse, op unaffected.
//  4 Encrypt, stub rd_out=rd_in+round_no, data_in=0 -> round_no 1..10, done 10 cycles after start edge,
//    data_out=36'd55.
//  5 Decrypt, stub rd_out=rd_in-round_no, data_in=36'd55 -> round_no 10..1, data_out=0. Then a start in the
//    done cycle is accepted with no idle gap.
//  6 Reset at round_no=5 in RUN -> busy=0 at once, no done, key_loaded=0; a new start gives err.

Source files
------------

// File: rtl/cipher_round_ctrl_if.sv
// Bundle between the round sequencer and its environment:
// serial key load, start/status handshake and round datapath.
interface cipher_round_ctrl_if #(
   parameter int WORD_W      = 9,
   parameter int NUM_WORDS   = 4,
   parameter int KEY_CHUNK_W = 16,
   parameter int KEY_W       = 144,
   parameter int RND_W       = 7
);
   localparam int STATE_W = WORD_W * NUM_WORDS;

   logic                   key_valid;
   logic [KEY_CHUNK_W-1:0] key_chunk;
   logic                   key_ready;
   logic                   key_loaded;
   logic [KEY_W-1:0]       key_out;
   logic                   start;
   logic                   mode;
   logic [STATE_W-1:0]     data_in;
   logic                   busy;
   logic                   done;
   logic                   err;
   logic [STATE_W-1:0]     data_out;
   logic [RND_W-1:0]       round_no;
   logic                   rd_mode;
   logic [STATE_W-1:0]     rd_in;
   logic [STATE_W-1:0]     rd_out;

   modport master (
      output key_valid, key_chunk, start, mode, data_in, rd_out,
      input  key_ready, key_loaded, key_out, busy, done, err,
      input  data_out, round_no, rd_mode, rd_in
   );

   modport slave (
      input  key_valid, key_chunk, start, mode, data_in, rd_out,
      output key_ready, key_loaded, key_out, busy, done, err,
      output data_out, round_no, rd_mode, rd_in
   );
endinterface

// File: rtl/cipher_round_ctrl.sv
// Encrypt/decrypt round sequencer for the toy block cipher:
// serial key load, round stepping and done/err status.
module cipher_round_ctrl #(
   parameter int WORD_W      = 9,
   parameter int NUM_WORDS   = 4,
   parameter int KEY_CHUNK_W = 16,
   parameter int KEY_W       = 144,
   parameter int NUM_ROUNDS  = 10,
   parameter int RND_W       = 7
) (
   input logic                clk,
   input logic                rst_n,
   cipher_round_ctrl_if.slave bus
);
   localparam int STATE_W = WORD_W * NUM_WORDS;
   localparam int NCHUNK  = KEY_W / KEY_CHUNK_W;
   localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             r_state;
   logic [KEY_W-1:0]   r_key;
   logic               r_loaded;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_done;
   logic               r_err;
   logic [STATE_W-1:0] r_dout;
   logic [RND_W-1:0]   r_rnd;
   logic               r_mode;
   logic [STATE_W-1:0] r_st;

   logic w_idle;
   logic w_key_acc;
   logic w_start_ok;
   logic w_start_bad;
   logic w_last;

   assign w_idle      = (r_state == S_IDLE);
   assign w_key_acc   = w_idle & ~bus.start & bus.key_valid;
   assign w_start_ok  = w_idle & bus.start & r_loaded
                        & (r_cnt == '0);
   assign w_start_bad = bus.start & ~w_start_ok;
   assign w_last      = r_mode ? (r_rnd == RND_W'(1))
                               : (r_rnd == RND_W'(NUM_ROUNDS));

   assign bus.key_ready  = w_idle & ~bus.start;
   assign bus.key_loaded = r_loaded;
   assign bus.key_out    = r_key;
   assign bus.busy       = (r_state == S_RUN);
   assign bus.done       = r_done;
   assign bus.err        = r_err;
   assign bus.data_out   = r_dout;
   assign bus.round_no   = r_rnd;
   assign bus.rd_mode    = r_mode;
   assign bus.rd_in      = r_st;

   // Sequencer: key shift-in, start acceptance and round iteration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_key    <= '0;
         r_loaded <= 1'b0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_dout   <= '0;
         r_rnd    <= '0;
         r_mode   <= 1'b0;
         r_st     <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= w_start_bad;
         unique case (r_state)
            S_IDLE: begin
               if (w_key_acc) begin
                  r_key <= {r_key[KEY_W-KEY_CHUNK_W-1:0],
                            bus.key_chunk};
                  if (r_cnt == CNT_W'(NCHUNK - 1)) begin
                     r_cnt    <= '0;
                     r_loaded <= 1'b1;
                  end else begin
                     r_cnt    <= r_cnt + 1'b1;
                     r_loaded <= 1'b0;
                  end
               end
               if (w_start_ok) begin
                  r_st    <= bus.data_in;
                  r_mode  <= bus.mode;
                  r_rnd   <= bus.mode ? RND_W'(NUM_ROUNDS)
                                      : RND_W'(1);
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_st <= bus.rd_out;
               if (w_last) begin
                  r_dout  <= bus.rd_out;
                  r_done  <= 1'b1;
                  r_rnd   <= '0;
                  r_state <= S_IDLE;
               end else if (r_mode) begin
                  r_rnd <= r_rnd - 1'b1;
               end else begin
                  r_rnd <= r_rnd + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cipher_round_ctrl.sv
// Scoreboard bench for cipher_round_ctrl with a stub
// round datapath and a round-by-round reference model.
module tb_cipher_round_ctrl;
   localparam int NR = 10;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   bit   mix;
   logic [35:0] exp_q[$];

   cipher_round_ctrl_if ifc ();

   cipher_round_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub datapath; mix selects a non-commutative round.
   function automatic logic [35:0] rnd(
      input logic [35:0] s, input logic [6:0] r, input logic m);
      logic [35:0] rr;
      rr = {29'd0, r};
      if (!mix) return m ? s - rr : s + rr;
      return m ? ({s[0], s[35:1]} ^ rr)
               : ({s[34:0], s[35]} + rr);
   endfunction

   assign ifc.rd_out = rnd(ifc.rd_in, ifc.round_no, ifc.rd_mode);

   // Reference: apply all rounds in order to the input.
   function automatic logic [35:0] model(
      input logic m, input logic [35:0] d);
      logic [35:0] s;
      s = d;
      for (int i = 1; i <= NR; i++)
         s = rnd(s, m ? 7'(NR + 1 - i) : 7'(i), m);
      return s;
   endfunction

   task automatic chk(input string nm,
                      input logic [143:0] act,
                      input logic [143:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Monitor: every done pops one expected result.
   always @(negedge clk) begin
      if (rst_n && ifc.done) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexp_done: got %0h want none",
                     ifc.data_out);
         end else begin
            logic [35:0] e;
            e = exp_q.pop_front();
            if (ifc.data_out !== e) begin
               bad++;
               $display("FAIL data_out: got %0h want %0h",
                        ifc.data_out, e);
            end
         end
      end
   end

   // Send chunks lo..hi of key k, with random gaps.
   task automatic load_key(input logic [143:0] k,
                           input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         ifc.key_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         ifc.key_chunk = k[143-16*i -: 16];
         ifc.key_valid = 1'b1;
         @(negedge clk);
         ifc.key_valid = 1'b0;
         if (i < 8) begin
            chk("kl_early", 144'(ifc.key_loaded), 144'd0);
         end else begin
            chk("kl_set", 144'(ifc.key_loaded), 144'd1);
            chk("key_out", ifc.key_out, k);
         end
      end
   endtask

   // Called at a negedge; returns at the negedge after.
   task automatic start_op(input logic m, input logic [35:0] d,
                           input bit ok);
      bit was_busy;
      was_busy = ifc.busy;
      ifc.start   = 1'b1;
      ifc.mode    = m;
      ifc.data_in = d;
      if (ok) exp_q.push_back(model(m, d));
      @(negedge clk);
      ifc.start = 1'b0;
      if (ok) begin
         chk("acc_busy", 144'(ifc.busy), 144'd1);
         chk("acc_rnd", 144'(ifc.round_no),
             m ? 144'(NR) : 144'd1);
      end else begin
         chk("err", 144'(ifc.err), 144'd1);
         chk("rej_busy", 144'(ifc.busy), 144'(was_busy));
      end
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (ifc.done) seen = 1'b1;
         else @(negedge clk);
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL done_timeout: got 0 want 1");
      end
   endtask

   initial begin
      logic [143:0] k;
      logic [35:0]  d;
      logic         m;
      bit           seen;
      total = 0;
      bad   = 0;
      mix   = 1'b0;
      rst_n = 1'b0;
      ifc.key_valid = 1'b0;
      ifc.key_chunk = '0;
      ifc.start     = 1'b0;
      ifc.mode      = 1'b0;
      ifc.data_in   = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 144'(ifc.key_ready), 144'd1);
      chk("rst_loaded", 144'(ifc.key_loaded), 144'd0);
      chk("rst_key", ifc.key_out, 144'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reject with no key
      start_op(1'b0, 36'd7, 1'b0);

      // Directed key 0001..0009, split by a rejected start
      k = '0;
      for (int i = 0; i < 9; i++) k = {k[127:0], 16'(i + 1)};
      load_key(k, 0, 3);
      start_op(1'b0, 36'd7, 1'b0);
      load_key(k, 4, 8);

      // Encrypt with round_no trace and exact latency
      start_op(1'b0, 36'd0, 1'b1);
      for (int j = 2; j <= NR; j++) begin
         @(negedge clk);
         chk("enc_rnd", 144'(ifc.round_no), 144'(j));
         chk("enc_nodone", 144'(ifc.done), 144'd0);
      end
      @(negedge clk);
      chk("enc_done", 144'(ifc.done), 144'd1);
      chk("enc_55", 144'(ifc.data_out), 144'd55);
      chk("idle_rnd", 144'(ifc.round_no), 144'd0);

      // Decrypt, then back-to-back start in the done cycle
      @(negedge clk);
      start_op(1'b1, 36'd55, 1'b1);
      for (int j = NR - 1; j >= 1; j--) begin
         @(negedge clk);
         chk("dec_rnd", 144'(ifc.round_no), 144'(j));
      end
      wait_done();
      chk("dec_0", 144'(ifc.data_out), 144'd0);
      start_op(1'b0, 36'h123456789, 1'b1);
      repeat (3) @(negedge clk);
      start_op(1'b1, 36'd1, 1'b0);
      wait_done();
      chk("key_hold", ifc.key_out, k);

      // Randomized operations
      mix = 1'b1;
      @(negedge clk);
      for (int n = 0; n < 12; n++) begin
         if (n % 4 == 0) begin
            k = {$urandom, $urandom, $urandom,
                 $urandom, 16'($urandom)};
            load_key(k, 0, 8);
         end
         m = 1'($urandom);
         d = {4'($urandom), $urandom};
         start_op(m, d, 1'b1);
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            start_op(~m, d, 1'b0);
         end
         wait_done();
         if ($urandom_range(0, 1) == 1)
            repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      // Reset in the middle of a run
      start_op(1'b0, 36'hABCDE, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (ifc.round_no == 7'd5) seen = 1'b1;
         else @(negedge clk);
      end
      chk("saw_rnd5", 144'(seen), 144'd1);
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      #1;
      chk("mr_busy", 144'(ifc.busy), 144'd0);
      chk("mr_loaded", 144'(ifc.key_loaded), 144'd0);
      chk("mr_key", ifc.key_out, 144'd0);
      chk("mr_rnd", 144'(ifc.round_no), 144'd0);
      chk("mr_dout", 144'(ifc.data_out), 144'd0);
      chk("mr_rdin", 144'(ifc.rd_in), 144'd0);
      chk("mr_done", 144'({ifc.done, ifc.err, ifc.rd_mode}), 144'd0);
      chk("mr_ready", 144'(ifc.key_ready), 144'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      start_op(1'b0, 36'd3, 1'b0);
      repeat (3) @(negedge clk);
      chk("q_empty", 144'(exp_q.size()), 144'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
